stream_mux_rr: RTL
==================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter NUM_CH, default 11: number of input channels, legal range 2..32.
REQ-002 SHALL have parameter DATA_W, default 40: payload width per channel.
REQ-003 SHALL have parameter MODE, default 0: 0 = external one-hot select, 1 = round-robin arbitration.
REQ-004 SHALL define CH_W = max(1, ceil(log2(NUM_CH))).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  NUM_CH  per-channel data-valid.
REQ-008 SHALL have port in_data  input  NUM_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port in_ready  output  NUM_CH  per-channel accept, combinational.
REQ-010 SHALL have port sel  input  NUM_CH  one-hot channel select, used only in MODE 0.
REQ-011 SHALL have port out_data  output  DATA_W  registered payload.
REQ-012 SHALL have port out_valid  output  1  out_data holds an unconsumed beat.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_ch  output  CH_W  index of the channel that supplied out_data.
REQ-015 SHALL have port sel_err  output  1  registered one-cycle pulse flagging an illegal select.

Function
REQ-016 SHALL hold a single output register stage; load_en = !out_valid || out_ready.
REQ-017 SHALL select at most one candidate channel c per cycle; in_ready[k] = load_en && (k == c), and all other in_ready bits are 0.
REQ-018 SHALL treat in_valid[c] && in_ready[c] as a transfer: out_data <= in_data[c], out_ch <= c, out_valid <= 1 on the next edge (latency 1 cycle).
REQ-019 SHALL clear out_valid when out_valid && out_ready and no transfer occurs in the same cycle.
REQ-020 SHALL keep out_valid at 1 and reload the register when consume and transfer occur in the same cycle, sustaining 1 beat/cycle.
REQ-021 SHALL hold out_data and out_ch stable while out_valid && !out_ready.
REQ-022 MODE 0: c is the set bit of sel when sel is exactly one-hot and in_valid at that bit is 1; otherwise there is no candidate.
REQ-023 MODE 0: when sel is zero or has more than one bit set, SHALL make no transfer, drive all in_ready to 0, and pulse sel_err high on the next cycle; sel_err is 0 otherwise.
REQ-024 MODE 1: SHALL ignore sel, tie sel_err to 0, and pick c as the first k with in_valid[k]=1, searching from ptr+1 upward and wrapping from NUM_CH-1 to 0.
REQ-025 MODE 1: SHALL update ptr to c only on a transfer, so a channel held off by backpressure keeps its priority.
REQ-026 SHALL never drop or duplicate a beat: each transfer produces exactly one out_valid && out_ready handshake.

Reset
REQ-027 SHALL, on rst_n low, immediately set out_valid=0, out_data=0, out_ch=0, sel_err=0 and ptr=NUM_CH-1, so channel 0 has first priority after reset.
REQ-028 SHALL drive all in_ready to 0 while rst_n is low.
REQ-029 SHALL discard an in-flight beat if reset asserts mid-operation; first transfer after release is no earlier than the first edge with rst_n high.

Verification (NUM_CH=11, DATA_W=40)
REQ-030 SHALL cover: MODE 0, sel=11'b00000000100, in_valid[2]=1, data 40'h12_3456_789A, out_ready=1 -> next cycle out_valid=1, out_data=40'h12_3456_789A, out_ch=2.
REQ-031 SHALL cover: MODE 0, sel=11'b00000000110 -> in_ready=0, no transfer, sel_err=1 for exactly one cycle.
REQ-032 SHALL cover: MODE 1, in_valid all 1s, out_ready=1 for 12 cycles after reset -> out_ch sequence 0,1,...,10,0.
REQ-033 SHALL cover: MODE 1, out_valid=1 with out_ready=0 for 5 cycles -> out_data/out_ch unchanged, in_ready=0, ptr unchanged; on the ready cycle the next channel transfers.
REQ-034 SHALL cover: transfer pending on ch 7 and out_valid=1 when rst_n pulses low -> outputs 0 immediately, and after release ch 0 wins if valid.
REQ-035 SHALL cover: MODE 1, only ch 10 valid, then only ch 0 valid -> out_ch 10 then 0, checking wrap-around.

Source files
------------

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
// N-to-1 valid/ready stream multiplexer with one registered output stage.
// MODE 0 takes a one-hot channel select from outside. MODE 1 arbitrates
// round-robin among the valid channels.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   [NUM_CH]         per-channel valid
//   in_data    in   [NUM_CH*DATA_W]  channel k at [k*DATA_W +: DATA_W]
//   in_ready   out  [NUM_CH]         per-channel accept (combinational)
//   sel        in   [NUM_CH]         one-hot select (MODE 0 only)
//   out_data   out  [DATA_W]         registered payload
//   out_valid  out                   out_data holds an unconsumed beat
//   out_ready  in                    downstream accept
//   out_ch     out  [CH_W]           source channel of out_data
//   sel_err    out                   one-cycle pulse after an illegal select
// ---------------------------------------------------------------------------
module stream_mux_rr #(
  parameter  int NUM_CH = 11,
  parameter  int DATA_W = 40,
  parameter  int MODE   = 0,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH-1:0]        sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic                     sel_err
);

  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic              r_sel_err;
  logic [CH_W-1:0]   r_ptr;

  logic              w_sel_onehot;
  logic              w_sel_has;
  logic [CH_W-1:0]   w_sel_idx;
  logic              w_rr_has;
  logic [CH_W-1:0]   w_rr_idx;
  logic              w_has_cand;
  logic [CH_W-1:0]   w_cand;
  logic              w_load_en;
  logic              w_xfer;
  logic [DATA_W-1:0] w_data_sel;

  // External select: legal only when exactly one bit is set.
  assign w_sel_onehot = (sel != '0) && ((sel & (sel - ONE)) == '0);
  assign w_sel_has    = w_sel_onehot && (|(sel & in_valid));

  always_comb begin
    w_sel_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel[k]) w_sel_idx = CH_W'(k);
    end
  end

  // Round-robin search starting at ptr+1. Walking the offsets from the far
  // end down lets the nearest valid channel overwrite any farther one.
  always_comb begin
    int j;
    j        = 0;
    w_rr_idx = '0;
    w_rr_has = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      j = int'(r_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (in_valid[j]) begin
        w_rr_idx = CH_W'(j);
        w_rr_has = 1'b1;
      end
    end
  end

  assign w_cand     = (MODE == 0) ? w_sel_idx : w_rr_idx;
  assign w_has_cand = (MODE == 0) ? w_sel_has : w_rr_has;
  assign w_load_en  = !r_out_valid || out_ready;
  // A candidate always has its valid set, so ready on it means a transfer.
  assign w_xfer     = rst_n && w_load_en && w_has_cand;
  assign w_data_sel = in_data[int'(w_cand)*DATA_W +: DATA_W];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready[gi] = w_xfer && (w_cand == CH_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_sel_err   <= 1'b0;
      r_ptr       <= CH_W'(NUM_CH - 1);
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data_sel;
        r_out_ch    <= w_cand;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Pointer moves only on a real transfer so a stalled winner keeps priority.
      if ((MODE == 1) && w_xfer) r_ptr <= w_cand;
      r_sel_err <= (MODE == 0) && !w_sel_onehot;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign sel_err   = r_sel_err;

endmodule
